// File: rtl/rob_alloc_ctrl_if.sv
// rtl/rob_alloc_ctrl_if.sv - dispatch, rename-allocate and commit signals of the ROB allocator
// Master is the decode/commit side; slave is rob_alloc_ctrl.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 3
`endif

interface rob_alloc_ctrl_if #(
    parameter int ROB_W = `ROB_ID_WIDTH
);
    logic             disp_valid;
    logic             disp_has_rd;
    logic [4:0]       disp_rd;
    logic             disp_ready;
    logic [ROB_W-1:0] disp_rob_id;
    logic             rat_we;
    logic [4:0]       rat_rw_addr;
    logic [ROB_W-1:0] rat_write_rob_id;
    logic             commit_valid;
    logic [ROB_W-1:0] commit_rob_id;

    modport master (
        output disp_valid, disp_has_rd, disp_rd, commit_valid, commit_rob_id,
        input  disp_ready, disp_rob_id, rat_we, rat_rw_addr, rat_write_rob_id
    );

    modport slave (
        input  disp_valid, disp_has_rd, disp_rd, commit_valid, commit_rob_id,
        output disp_ready, disp_rob_id, rat_we, rat_rw_addr, rat_write_rob_id
    );
endinterface

// File: rtl/rob_alloc_ctrl.sv
// rtl/rob_alloc_ctrl.sv - in-order ROB tag allocator with post-flush drain sequencing
// Define ROB_ALLOC_PERF_EN to build the saturating dispatch stall counter.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 3
`endif

module rob_alloc_ctrl #(
    parameter int ROB_W     = `ROB_ID_WIDTH,
    parameter int DRAIN_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    rob_alloc_ctrl_if.slave     disp,
    output logic [ROB_W:0]      alloc_count_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                err_o,
    output logic [31:0]         stall_cycles_o
);
    localparam logic [0:0]   S_RUN   = 1'b0;
    localparam logic [0:0]   S_DRAIN = 1'b1;
    localparam logic [ROB_W:0] DEPTH = {1'b1, {ROB_W{1'b0}}};
    localparam logic [3:0]   DRAIN_LOAD = (DRAIN_CYC == 0) ? 4'd0 : 4'(DRAIN_CYC - 1);

    logic [ROB_W-1:0] head_q, head_d;
    logic [ROB_W-1:0] tail_q, tail_d;
    logic [ROB_W:0]   count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic             err_q, err_d;

    logic fire;
    logic commit_ok;
    logic commit_bad;
    logic run_cycle;

    assign full_o  = (count_q == DEPTH);
    assign empty_o = (count_q == '0);
    assign err_o   = err_q;
    assign alloc_count_o = count_q;

    assign disp.disp_ready       = (state_q == S_RUN) & ~full_o & ~flush_i;
    assign disp.disp_rob_id      = tail_q;
    assign fire                  = disp.disp_valid & disp.disp_ready;
    assign disp.rat_we           = fire & disp.disp_has_rd & (disp.disp_rd != 5'd0);
    assign disp.rat_rw_addr      = disp.disp_rd;
    assign disp.rat_write_rob_id = tail_q;

    // Commits are only judged in RUN; flush and drain swallow them silently.
    assign run_cycle  = (state_q == S_RUN) & ~flush_i;
    assign commit_ok  = run_cycle & disp.commit_valid & ~empty_o & (disp.commit_rob_id == head_q);
    assign commit_bad = run_cycle & disp.commit_valid & (empty_o | (disp.commit_rob_id != head_q));

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        drain_d = drain_q;
        err_d   = err_q | commit_bad;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (DRAIN_CYC != 0) begin
                state_d = S_DRAIN;
                drain_d = DRAIN_LOAD;
            end
        end else if (state_q == S_DRAIN) begin
            if (drain_q == 4'd0) state_d = S_RUN;
            else                 drain_d = drain_q - 4'd1;
        end else begin
            if (commit_ok) head_d = head_q + 1'b1;
            if (fire)      tail_d = tail_q + 1'b1;
            unique case ({fire, commit_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= S_RUN;
            drain_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

`ifdef ROB_ALLOC_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (disp.disp_valid & ~disp.disp_ready & (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// tb/tb_rob_alloc_ctrl.sv - scenario and randomized checks of rob_alloc_ctrl against a queue model
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 3
`endif

module tb_rob_alloc_ctrl;
    localparam int W     = `ROB_ID_WIDTH;
    localparam int DEPTH = 1 << W;
    localparam int DRAIN = 2;
    localparam int PW    = 1 + W + 1 + 5 + W + (W + 1) + 3 + 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic [W:0]   alloc_count;
    logic         full, empty, err;
    logic [31:0]  stall_cycles;

    rob_alloc_ctrl_if #(.ROB_W(W)) bus();

    rob_alloc_ctrl #(.ROB_W(W), .DRAIN_CYC(DRAIN)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush),
        .disp           (bus),
        .alloc_count_o  (alloc_count),
        .full_o         (full),
        .empty_o        (empty),
        .err_o          (err),
        .stall_cycles_o (stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: queue of in-flight IDs, next ID to hand out, remaining drain cycles.
    int     q[$];
    int     m_tail;
    int     m_drain;
    bit     m_err;
    longint m_stall;
    bit     m_ready, m_fire, m_we;

    function automatic void model_reset();
        q.delete();
        m_tail  = 0;
        m_drain = 0;
        m_err   = 1'b0;
        m_stall = 0;
    endfunction

    function automatic void model_comb();
        m_ready = (m_drain == 0) && (q.size() < DEPTH) && !flush;
        m_fire  = bus.disp_valid && m_ready;
        m_we    = m_fire && bus.disp_has_rd && (bus.disp_rd != 5'd0);
    endfunction

    function automatic void model_edge();
        bit ok;
        if (!rst) begin
            model_reset();
            return;
        end
        model_comb();
        if (bus.disp_valid && !m_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (flush) begin
            q.delete();
            m_tail  = 0;
            m_drain = DRAIN;
        end else if (m_drain > 0) begin
            m_drain--;
        end else begin
            ok = (q.size() > 0) && (int'(bus.commit_rob_id) == q[0]);
            if (bus.commit_valid) begin
                if (ok) void'(q.pop_front());
                else    m_err = 1'b1;
            end
            if (m_fire) begin
                q.push_back(m_tail);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    endfunction

    function automatic logic [PW-1:0] dut_vec();
        return {bus.disp_ready, bus.disp_rob_id, bus.rat_we, bus.rat_rw_addr,
                bus.rat_write_rob_id, alloc_count, full, empty, err, stall_cycles};
    endfunction

    function automatic logic [PW-1:0] model_vec();
        logic [W-1:0] t;
        logic [W:0]   c;
        logic [31:0]  s;
        model_comb();
        t = W'(m_tail);
        c = (W + 1)'(q.size());
`ifdef ROB_ALLOC_PERF_EN
        s = 32'(m_stall);
`else
        s = 32'd0;
`endif
        return {m_ready, t, m_we, bus.disp_rd, t, c, q.size() == DEPTH, q.size() == 0, m_err, s};
    endfunction

    task automatic set_in(input bit v, input bit hr, input logic [4:0] rd,
                          input bit cv, input logic [W-1:0] cid, input bit fl);
        bus.disp_valid    = v;
        bus.disp_has_rd   = hr;
        bus.disp_rd       = rd;
        bus.commit_valid  = cv;
        bus.commit_rob_id = cid;
        flush             = fl;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_in(0, 0, 5'd0, 0, '0, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        set_in(0, 0, 5'd0, 0, '0, 0);
        rst = 1'b0;
        step();
        step();
        #1;
        if ({bus.disp_ready, bus.rat_we, full, empty, err, alloc_count, bus.disp_rob_id, stall_cycles} !==
            {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (W + 1)'(0), W'(0), 32'd0}) begin
            errors++;
            $display("FAIL reset_values got ready=%b we=%b full=%b empty=%b err=%b cnt=%0d id=%0d stall=%0d",
                     bus.disp_ready, bus.rat_we, full, empty, err, alloc_count, bus.disp_rob_id, stall_cycles);
        end
        checks++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_dispatch();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 5'd5, 0, '0, 0);
            #1;
            if (bus.disp_rob_id !== W'(i) || bus.rat_we !== 1'b1 || bus.rat_rw_addr !== 5'd5) begin
                errors++;
                $display("FAIL dispatch_id%0d got id=%0d we=%b addr=%0d want id=%0d we=1 addr=5",
                         i, bus.disp_rob_id, bus.rat_we, bus.rat_rw_addr, i);
            end
            checks++;
            step();
        end
        set_in(0, 0, 5'd0, 0, '0, 0);
        #1;
        if (alloc_count !== (W + 1)'(3)) begin
            errors++;
            $display("FAIL dispatch_count got %0d want 3", alloc_count);
        end
        checks++;
    endtask

    task automatic test_rd_zero();
        set_in(1, 1, 5'd0, 0, '0, 0);
        #1;
        if (bus.rat_we !== 1'b0 || bus.disp_ready !== 1'b1 || bus.disp_rob_id !== W'(3)) begin
            errors++;
            $display("FAIL rd_zero got we=%b ready=%b id=%0d want we=0 ready=1 id=3",
                     bus.rat_we, bus.disp_ready, bus.disp_rob_id);
        end
        checks++;
        step();
        set_in(0, 0, 5'd0, 0, '0, 0);
        #1;
        if (bus.disp_rob_id !== W'(4) || alloc_count !== (W + 1)'(4)) begin
            errors++;
            $display("FAIL rd_zero_advance got id=%0d cnt=%0d want id=4 cnt=4", bus.disp_rob_id, alloc_count);
        end
        checks++;
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < DEPTH - 4; i++) begin
            set_in(1, 1, 5'($urandom_range(31)), 0, '0, 0);
            #1;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL fill_%0d dut=%h model=%h", i, dut_vec(), model_vec());
            end
            checks++;
            step();
        end
        set_in(1, 1, 5'd7, 1, W'(0), 0);
        #1;
        if (full !== 1'b1 || bus.disp_ready !== 1'b0 || bus.rat_we !== 1'b0) begin
            errors++;
            $display("FAIL full_no_bypass got full=%b ready=%b we=%b want 1 0 0", full, bus.disp_ready, bus.rat_we);
        end
        checks++;
        step();
        set_in(1, 1, 5'd9, 0, '0, 0);
        #1;
        if (alloc_count !== (W + 1)'(DEPTH - 1) || bus.disp_rob_id !== W'(0) || bus.disp_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap got cnt=%0d id=%0d ready=%b want cnt=%0d id=0 ready=1",
                     alloc_count, bus.disp_rob_id, bus.disp_ready, DEPTH - 1);
        end
        checks++;
        step();
        while (q.size() > 3) begin
            set_in(0, 0, 5'd0, 1, W'(q[0]), 0);
            #1;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL drain_commit dut=%h model=%h", dut_vec(), model_vec());
            end
            checks++;
            step();
        end
    endtask

    task automatic test_flush();
        set_in(1, 1, 5'd3, 1, W'(q[0]), 1);
        #1;
        if (bus.disp_ready !== 1'b0 || bus.rat_we !== 1'b0 || alloc_count !== (W + 1)'(3)) begin
            errors++;
            $display("FAIL flush_cycle got ready=%b we=%b cnt=%0d want 0 0 3", bus.disp_ready, bus.rat_we, alloc_count);
        end
        checks++;
        step();
        for (int i = 0; i < DRAIN; i++) begin
            set_in(1, 1, 5'd4, 1, W'(0), 0);
            #1;
            if (bus.disp_ready !== 1'b0 || alloc_count !== '0 || bus.disp_rob_id !== W'(0) || err !== 1'b0) begin
                errors++;
                $display("FAIL drain_%0d got ready=%b cnt=%0d id=%0d err=%b want 0 0 0 0",
                         i, bus.disp_ready, alloc_count, bus.disp_rob_id, err);
            end
            checks++;
            step();
        end
        set_in(1, 1, 5'd4, 0, '0, 0);
        #1;
        if (bus.disp_ready !== 1'b1 || bus.disp_rob_id !== W'(0) || bus.rat_we !== 1'b1) begin
            errors++;
            $display("FAIL post_drain got ready=%b id=%0d we=%b want 1 0 1", bus.disp_ready, bus.disp_rob_id, bus.rat_we);
        end
        checks++;
        step();
        set_in(0, 0, 5'd0, 0, '0, 0);
    endtask

    task automatic test_err();
        do_reset();
        set_in(0, 0, 5'd0, 1, W'(0), 0);
        step();
        set_in(0, 0, 5'd0, 0, '0, 0);
        #1;
        if (err !== 1'b1 || alloc_count !== '0) begin
            errors++;
            $display("FAIL err_empty got err=%b cnt=%0d want 1 0", err, alloc_count);
        end
        checks++;
        set_in(1, 1, 5'd1, 0, '0, 0);
        step();
        step();
        set_in(0, 0, 5'd0, 1, W'(1), 0);
        step();
        set_in(0, 0, 5'd0, 1, W'(0), 0);
        #1;
        if (err !== 1'b1 || alloc_count !== (W + 1)'(2)) begin
            errors++;
            $display("FAIL err_wrong_id got err=%b cnt=%0d want 1 2", err, alloc_count);
        end
        checks++;
        step();
        set_in(0, 0, 5'd0, 0, '0, 0);
        #1;
        if (err !== 1'b1 || alloc_count !== (W + 1)'(1)) begin
            errors++;
            $display("FAIL err_sticky got err=%b cnt=%0d want 1 1", err, alloc_count);
        end
        checks++;
    endtask

    task automatic test_stall();
        logic [31:0] want;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 1, 5'd2, 0, '0, 0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1, 1, 5'd2, 0, '0, 0);
            step();
        end
        set_in(0, 0, 5'd0, 0, '0, 0);
        #1;
`ifdef ROB_ALLOC_PERF_EN
        want = 32'd5;
`else
        want = 32'd0;
`endif
        if (stall_cycles !== want || full !== 1'b1) begin
            errors++;
            $display("FAIL stall_count got stall=%0d full=%b want stall=%0d full=1", stall_cycles, full, want);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 5'd6, 0, '0, 0);
            step();
        end
        set_in(0, 0, 5'd0, 0, '0, 0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        if ({bus.disp_ready, bus.rat_we, full, empty, err, alloc_count, bus.disp_rob_id, stall_cycles} !==
            {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (W + 1)'(0), W'(0), 32'd0}) begin
            errors++;
            $display("FAIL async_reset got ready=%b we=%b full=%b empty=%b err=%b cnt=%0d id=%0d stall=%0d",
                     bus.disp_ready, bus.rat_we, full, empty, err, alloc_count, bus.disp_rob_id, stall_cycles);
        end
        checks++;
        step();
        rst = 1'b1;
    endtask

    task automatic test_random();
        bit          v, cv, fl;
        logic [W-1:0] cid;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(3) != 0);
            cv = ($urandom_range(1) != 0);
            fl = ($urandom_range(24) == 0);
            cid = (q.size() > 0 && $urandom_range(7) != 0) ? W'(q[0]) : W'($urandom_range(DEPTH - 1));
            set_in(v, 1'($urandom_range(1)), 5'($urandom_range(31)), cv, cid, fl);
            #1;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random_%0d dut=%h model=%h", i, dut_vec(), model_vec());
            end
            checks++;
            step();
        end
        set_in(0, 0, 5'd0, 0, '0, 0);
    endtask

    initial begin
        set_in(0, 0, 5'd0, 0, '0, 0);
        @(negedge clk);
        test_reset();
        test_dispatch();
        test_rd_zero();
        test_full_wrap();
        test_flush();
        test_err();
        test_stall();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
